// File: rtl/pipe_scheduler.sv
// Two-pipe scroller and scorer (IDLE/RUN/DEAD) with LFSR-driven gap heights.
// Define PIPE_SPEEDUP_EN to make the scroll speed rise by one every 8 points, capped at SPEED+2.
module pipe_scheduler #(
  parameter int unsigned PIPE_WIDTH = 40,
  parameter int unsigned SPACING    = 250,
  parameter int unsigned SPEED      = 2,
  parameter int unsigned BIRD_X     = 150,
  parameter int unsigned GAP_MIN    = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frameTick,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] pipe1X,
  output logic [9:0] pipe2X,
  output logic [9:0] gap1Top,
  output logic [9:0] gap2Top,
  output logic [7:0] score,
  output logic       scorePulse,
  output logic       running
);

  localparam int unsigned XW = 10;
  localparam int unsigned AW = 11;
  localparam logic [XW-1:0] X1_IDLE    = XW'(640);
  localparam logic [XW-1:0] X2_IDLE    = XW'(640 + SPACING);
  localparam logic [XW-1:0] G1_IDLE    = XW'(180);
  localparam logic [XW-1:0] G2_IDLE    = XW'(240);
  localparam logic [XW-1:0] SPEED_INIT = XW'(SPEED);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_e;

  state_e                 state_q, state_d;
  logic [1:0][XW-1:0]     x_q, x_d;
  logic [1:0][XW-1:0]     g_q, g_d;
  logic [7:0]             score_q, score_d;
  logic                   pulse_q, pulse_d;
  logic                   running_q, running_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [XW-1:0]          speed_q, speed_d;

  logic [1:0][XW-1:0]     step_x;
  logic [1:0]             respawn;
  logic [1:0]             hit;
  logic [8:0]             score_sum;
  logic [7:0]             score_sat;

  // Per-pipe next position after one tick, and whether it crossed the bird column.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      respawn[i] = x_q[i] < speed_q;
      step_x[i]  = respawn[i] ? XW'(AW'(x_q[i]) + AW'(2 * SPACING) - AW'(speed_q))
                              : x_q[i] - speed_q;
      hit[i]     = (AW'(x_q[i]) + AW'(PIPE_WIDTH) > AW'(BIRD_X)) &&
                   (AW'(step_x[i]) + AW'(PIPE_WIDTH) <= AW'(BIRD_X));
    end
    score_sum = 9'(score_q) + 9'(hit[0]) + 9'(hit[1]);
    score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    g_d     = g_q;
    score_d = score_q;
    pulse_d = 1'b0;
    speed_d = speed_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // Collision wins over a same-cycle tick: nothing moves.
        if (collision) begin
          state_d = S_DEAD;
        end else if (frameTick) begin
          x_d = step_x;
          for (int i = 0; i < 2; i++) begin
            if (respawn[i]) g_d[i] = XW'(GAP_MIN) + XW'(lfsr_q[7:0]);
          end
          if (|hit) begin
            pulse_d = 1'b1;
            score_d = score_sat;
`ifdef PIPE_SPEEDUP_EN
            if ((score_sat[7:3] != score_q[7:3]) && (speed_q < XW'(SPEED + 2)))
              speed_d = speed_q + XW'(1);
`endif
          end
        end
      end
      S_DEAD: begin
        if (start) begin
          state_d = S_IDLE;
          x_d     = {X2_IDLE, X1_IDLE};
          g_d     = {G2_IDLE, G1_IDLE};
          score_d = 8'd0;
          speed_d = SPEED_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= {X2_IDLE, X1_IDLE};
      g_q       <= {G2_IDLE, G1_IDLE};
      score_q   <= 8'd0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      speed_q   <= SPEED_INIT;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      g_q       <= g_d;
      score_q   <= score_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
      lfsr_q    <= lfsr_d;
      speed_q   <= speed_d;
    end
  end

  assign pipe1X     = x_q[0];
  assign pipe2X     = x_q[1];
  assign gap1Top    = g_q[0];
  assign gap2Top    = g_q[1];
  assign score      = score_q;
  assign scorePulse = pulse_q;
  assign running    = running_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: game-level reference model checked every cycle, plus directed literals.
module tb_pipe_scheduler;

  localparam int PW = 40, SP = 250, SPD = 2, BX = 150, GMIN = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frameTick = 1'b0, start = 1'b0, collision = 1'b0;
  logic [9:0] pipe1X, pipe2X, gap1Top, gap2Top;
  logic [7:0] score;
  logic       scorePulse, running;

  pipe_scheduler #(.PIPE_WIDTH(PW), .SPACING(SP), .SPEED(SPD), .BIRD_X(BX), .GAP_MIN(GMIN)) dut (
    .clk(clk), .rst_n(rst_n), .frameTick(frameTick), .start(start), .collision(collision),
    .pipe1X(pipe1X), .pipe2X(pipe2X), .gap1Top(gap1Top), .gap2Top(gap2Top),
    .score(score), .scorePulse(scorePulse), .running(running)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Game model: 0=idle 1=run 2=dead
  int          m_st, m_score, m_speed;
  int          m_x[2], m_g[2];
  bit          m_pulse, m_run;
  logic [15:0] m_lf, m_cur;

  task automatic model_idle();
    m_st = 0; m_x[0] = 640; m_x[1] = 640 + SP; m_g[0] = 180; m_g[1] = 240;
    m_score = 0; m_speed = SPD;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_idle();
      m_lf = 16'hACE1; m_pulse = 0; m_run = 0;
    end else begin
      int pts, nx, old;
      m_cur = m_lf;
      m_lf  = {m_lf[14:0], m_lf[15] ^ m_lf[13] ^ m_lf[12] ^ m_lf[10]};
      m_pulse = 0;
      if (m_st == 0) begin
        if (start) m_st = 1;
      end else if (m_st == 1) begin
        if (collision) m_st = 2;
        else if (frameTick) begin
          pts = 0;
          for (int i = 0; i < 2; i++) begin
            if (m_x[i] < m_speed) begin
              nx = m_x[i] + 2 * SP - m_speed;
              m_g[i] = GMIN + int'(m_cur[7:0]);
            end else nx = m_x[i] - m_speed;
            if ((m_x[i] + PW > BX) && (nx + PW <= BX)) pts++;
            m_x[i] = nx;
          end
          if (pts > 0) begin
            old = m_score;
            m_score = (m_score + pts > 255) ? 255 : m_score + pts;
            m_pulse = 1;
`ifdef PIPE_SPEEDUP_EN
            if ((m_score / 8 != old / 8) && (m_speed < SPD + 2)) m_speed++;
`endif
          end
        end
      end else if (start) begin
        model_idle();
      end
      m_run = (m_st == 1);
    end
  end

  // Every-cycle comparison of the full output bundle against the model.
  always @(negedge clk) begin
    chk("outputs {p1,p2,g1,g2,score,pulse,run}",
        64'({pipe1X, pipe2X, gap1Top, gap2Top, score, scorePulse, running}),
        64'({10'(m_x[0]), 10'(m_x[1]), 10'(m_g[0]), 10'(m_g[1]), 8'(m_score), m_pulse, m_run}));
  end

  task automatic step(input logic s, input logic t, input logic c);
    start = s; frameTick = t; collision = c;
    @(posedge clk); #2;
    start = 0; frameTick = 0; collision = 0;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_p1", 64'(pipe1X), 64'd640);
    chk("reset_p2", 64'(pipe2X), 64'd890);
    chk("reset_g1", 64'(gap1Top), 64'd180);
    chk("reset_g2", 64'(gap2Top), 64'd240);
    chk("reset_score_pulse_run", 64'({score, scorePulse, running}), 64'd0);
    rst_n = 1'b1;

    step(1, 0, 0);
    step(0, 1, 0);
    chk("tick1_p1", 64'(pipe1X), 64'd638);
    chk("tick1_p2", 64'(pipe2X), 64'd888);
    chk("tick1_running", 64'(running), 64'd1);

    repeat (263) step(0, 1, 0);
    chk("tick264_p1", 64'(pipe1X), 64'd112);
    chk("tick264_score", 64'(score), 64'd0);
    step(0, 1, 0);
    chk("tick265_p1", 64'(pipe1X), 64'd110);
    chk("tick265_pulse", 64'(scorePulse), 64'd1);
    chk("tick265_score", 64'(score), 64'd1);
    step(0, 0, 0);
    chk("pulse_one_cycle", 64'(scorePulse), 64'd0);

    repeat (55) step(0, 1, 0);
    chk("tick320_p1", 64'(pipe1X), 64'd0);
    step(0, 1, 0);
    chk("tick321_respawn", 64'(pipe1X), 64'd498);
    chk("tick321_p2", 64'(pipe2X), 64'd248);
    chk("gap1_range", 64'((gap1Top >= 10'd40) && (gap1Top <= 10'd295)), 64'd1);

    step(0, 1, 1);
    chk("dead_running", 64'(running), 64'd0);
    chk("dead_p1_frozen", 64'(pipe1X), 64'd498);
    chk("dead_p2_frozen", 64'(pipe2X), 64'd248);
    step(0, 1, 0);
    chk("dead_tick_ignored", 64'({pipe1X, pipe2X, score}), 64'({10'd498, 10'd248, 8'd1}));
    step(1, 0, 0);
    chk("restart_idle", 64'({pipe1X, pipe2X, gap1Top, gap2Top, score, running}),
        64'({10'd640, 10'd890, 10'd180, 10'd240, 8'd0, 1'b0}));
    step(1, 0, 0);
    step(1, 1, 0);
    chk("start_in_run_ignored", 64'({pipe1X, running}), 64'({10'd638, 1'b1}));

    pulses = 0;
    for (int n = 0; n < 40000 && pulses < 256; n++) begin
      step(0, 1, 0);
      if (scorePulse) begin
        pulses++;
        if (pulses == 254) chk("score_at_254", 64'(score), 64'd254);
        if (pulses == 255) chk("score_at_255", 64'(score), 64'd255);
        if (pulses == 256) chk("score_saturated", 64'(score), 64'd255);
      end
    end
    chk("pulses_total", 64'(pulses), 64'd256);

    repeat (3) step(0, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({pipe1X, pipe2X, gap1Top, gap2Top, score, scorePulse, running}),
        64'({10'd640, 10'd890, 10'd180, 10'd240, 8'd0, 1'b0, 1'b0}));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
